// File: rtl/bp_fe_pkg.sv
// Shared front-end types and constants for the branch-predictor update path.
// The prediction-entry struct is declared through a macro so each user picks its own index width.
package bp_fe_pkg;

  localparam int bp_fe_bp_stat_width_gp = 32;

  // Saturating increment used by the statistics counters.
  function automatic logic [bp_fe_bp_stat_width_gp-1:0] bp_fe_sat_inc(
    input logic [bp_fe_bp_stat_width_gp-1:0] value
  );
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

`define DECLARE_BP_FE_BP_PRED_ENTRY_S(idx_width_mp) \
  typedef struct packed {                            \
    logic [idx_width_mp-1:0] idx;                    \
    logic                    taken;                  \
  } bp_fe_bp_pred_entry_s

// File: rtl/bp_fe_bp_pred_fifo.sv
// Generic circular FIFO: read/write pointers, occupancy count, flush clears state.
// A push in the same cycle as a flush is discarded; a pop in that cycle still happens.
module bp_fe_bp_pred_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         i_push,
  input  logic [width_p-1:0]           i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [width_p-1:0]           o_head,
  output logic                         o_ready,
  output logic                         o_pop_v,
  output logic [$clog2(els_p+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(els_p);
  localparam int CNT_W = $clog2(els_p + 1);

  logic [width_p-1:0] r_mem [els_p];
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   r_wptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_ready = (r_count != CNT_W'(els_p));
  assign w_push  = i_push & o_ready & ~i_flush;
  assign w_pop   = i_pop & (r_count != '0);
  assign o_pop_v = w_pop;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // NOTE: storage has no reset; a slot is only read after a push has written it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// Pairs in-order branch resolutions with queued predictions and drives one registered BHT write each.
// Optional statistics counters are built only when BP_FE_BP_UPDATE_STATS_EN is defined.
module bp_fe_bp_update_queue
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int queue_els_p     = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              pred_v_i,
  input  logic [bht_idx_width_p-1:0]        pred_idx_i,
  input  logic                              pred_taken_i,
  output logic                              pred_ready_o,
  input  logic                              res_v_i,
  input  logic                              res_taken_i,
  input  logic                              flush_i,
  output logic                              w_v_o,
  output logic [bht_idx_width_p-1:0]        idx_w_o,
  output logic                              correct_o,
  output logic [$clog2(queue_els_p+1)-1:0]  count_o,
  output logic [bp_fe_bp_stat_width_gp-1:0] stat_resolved_o,
  output logic [bp_fe_bp_stat_width_gp-1:0] stat_mispred_o
);

  `DECLARE_BP_FE_BP_PRED_ENTRY_S(bht_idx_width_p);

  bp_fe_bp_pred_entry_s       w_push_entry;
  bp_fe_bp_pred_entry_s       w_head;
  logic                       w_pop_v;
  logic                       w_correct;
  logic                       r_w_v;
  logic [bht_idx_width_p-1:0] r_idx_w;
  logic                       r_correct;

  assign w_push_entry = '{idx: pred_idx_i, taken: pred_taken_i};

  bp_fe_bp_pred_fifo #(
    .width_p ($bits(bp_fe_bp_pred_entry_s)),
    .els_p   (queue_els_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_push    (pred_v_i),
    .i_data    (w_push_entry),
    .i_pop     (res_v_i),
    .i_flush   (flush_i),
    .o_head    (w_head),
    .o_ready   (pred_ready_o),
    .o_pop_v   (w_pop_v),
    .o_count   (count_o)
  );

  assign w_correct = (w_head.taken == res_taken_i);

  // Index and direction hold between writes; only w_v_o qualifies them.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_w_v     <= 1'b0;
      r_idx_w   <= '0;
      r_correct <= 1'b0;
    end else begin
      r_w_v <= w_pop_v;
      if (w_pop_v) begin
        r_idx_w   <= w_head.idx;
        r_correct <= w_correct;
      end
    end
  end

  assign w_v_o     = r_w_v;
  assign idx_w_o   = r_idx_w;
  assign correct_o = r_correct;

`ifdef BP_FE_BP_UPDATE_STATS_EN
  logic [bp_fe_bp_stat_width_gp-1:0] r_stat_resolved;
  logic [bp_fe_bp_stat_width_gp-1:0] r_stat_mispred;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else if (w_pop_v) begin
      r_stat_resolved <= bp_fe_sat_inc(r_stat_resolved);
      if (!w_correct) r_stat_mispred <= bp_fe_sat_inc(r_stat_mispred);
    end
  end

  assign stat_resolved_o = r_stat_resolved;
  assign stat_mispred_o  = r_stat_mispred;
`else
  assign stat_resolved_o = '0;
  assign stat_mispred_o  = '0;
`endif

  // A prediction offered while full is dropped; upstream should have honoured pred_ready_o.
  push_while_full_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(pred_v_i && !pred_ready_o)
  ) else $warning("prediction dropped: queue full");

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed + random bench for bp_fe_bp_update_queue with a prediction model and an update scoreboard.
// Statistics expectations follow BP_FE_BP_UPDATE_STATS_EN.
module tb_bp_fe_bp_update_queue;

  localparam int IW  = 4;
  localparam int ELS = 8;
  localparam int CW  = $clog2(ELS + 1);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          pred_v_i;
  logic [IW-1:0] pred_idx_i;
  logic          pred_taken_i;
  logic          pred_ready_o;
  logic          res_v_i;
  logic          res_taken_i;
  logic          flush_i;
  logic          w_v_o;
  logic [IW-1:0] idx_w_o;
  logic          correct_o;
  logic [CW-1:0] count_o;
  logic [31:0]   stat_resolved_o;
  logic [31:0]   stat_mispred_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bp_update_queue #(
    .bht_idx_width_p (IW),
    .queue_els_p     (ELS)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .pred_v_i        (pred_v_i),
    .pred_idx_i      (pred_idx_i),
    .pred_taken_i    (pred_taken_i),
    .pred_ready_o    (pred_ready_o),
    .res_v_i         (res_v_i),
    .res_taken_i     (res_taken_i),
    .flush_i         (flush_i),
    .w_v_o           (w_v_o),
    .idx_w_o         (idx_w_o),
    .correct_o       (correct_o),
    .count_o         (count_o),
    .stat_resolved_o (stat_resolved_o),
    .stat_mispred_o  (stat_mispred_o)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic          taken;
  } pred_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic          correct;
  } upd_t;

  pred_t       model_q[$];
  upd_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_res  = '0;
  logic [31:0] exp_mis  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_outputs();
    upd_t u;
    if (exp_q.size() > 0) begin
      u = exp_q.pop_front();
      check("w_v", 32'(w_v_o), 32'd1);
      check("idx_w", 32'(idx_w_o), 32'(u.idx));
      check("correct", 32'(correct_o), 32'(u.correct));
    end else begin
      check("w_v_idle", 32'(w_v_o), 32'd0);
    end
    check("count", 32'(count_o), 32'(model_q.size()));
    check("ready", 32'(pred_ready_o), 32'(model_q.size() != ELS));
`ifdef BP_FE_BP_UPDATE_STATS_EN
    check("stat_res", stat_resolved_o, exp_res);
    check("stat_mis", stat_mispred_o, exp_mis);
`else
    check("stat_res", stat_resolved_o, 32'd0);
    check("stat_mis", stat_mispred_o, 32'd0);
`endif
  endtask

  // One clock of stimulus; the model is advanced with the same ordering the hardware must honour.
  task automatic step(input logic pv, input logic [IW-1:0] pidx, input logic ptaken,
                      input logic rv, input logic rtaken, input logic fl);
    pred_t h;
    bit    pop_ok;
    bit    push_ok;
    pred_v_i     = pv;
    pred_idx_i   = pidx;
    pred_taken_i = ptaken;
    res_v_i      = rv;
    res_taken_i  = rtaken;
    flush_i      = fl;
    pop_ok  = rv && (model_q.size() > 0);
    push_ok = pv && (model_q.size() < ELS) && !fl;
    if (pop_ok) begin
      h = model_q.pop_front();
      exp_q.push_back('{idx: h.idx, correct: (h.taken == rtaken)});
      exp_res++;
      if (h.taken != rtaken) exp_mis++;
    end
    if (push_ok) model_q.push_back('{idx: pidx, taken: ptaken});
    if (fl) model_q.delete();
    @(posedge clk_i);
    #1;
    pred_v_i = 1'b0;
    res_v_i  = 1'b0;
    flush_i  = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset(input logic rv);
    reset_n_i = 1'b0;
    res_v_i   = rv;
    @(posedge clk_i);
    #1;
    res_v_i = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_res = '0;
    exp_mis = '0;
    check("rst_w_v", 32'(w_v_o), 32'd0);
    check("rst_idx", 32'(idx_w_o), 32'd0);
    check("rst_correct", 32'(correct_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ready", 32'(pred_ready_o), 32'd1);
    check("rst_stat_res", stat_resolved_o, 32'd0);
    check("rst_stat_mis", stat_mispred_o, 32'd0);
    reset_n_i = 1'b1;
  endtask

  initial begin
    logic [IW-1:0] k4;
    reset_n_i    = 1'b0;
    pred_v_i     = 1'b0;
    pred_idx_i   = '0;
    pred_taken_i = 1'b0;
    res_v_i      = 1'b0;
    res_taken_i  = 1'b0;
    flush_i      = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset(1'b0);

    // Single push then resolve.
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Fill, overflow push, drain with all not-taken.
    for (int i = 0; i < ELS; i++) begin
      k4 = IW'(i);
      step(1'b1, k4, k4[0], 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ELS; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Full queue: simultaneous push and pop only pops.
    for (int i = 0; i < ELS; i++) step(1'b1, IW'(i + 3), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Steady push+pop at count 3 well past two pointer wraps.
    for (int i = 0; i < 2 * ELS + 4; i++) begin
      step(1'b1, IW'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'b0);
    end

    // Flush with a resolve and a push in the same cycle.
    step(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Empty resolve, then reset with four queued and a resolve pending.
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, IW'(i + 10), 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Ten resolutions, three mispredicted (global resolutions 2, 5, 8).
    for (int blk = 0; blk < 2; blk++) begin
      for (int k = 0; k < 5; k++) begin
        k4 = IW'(k);
        step(1'b1, IW'(blk * 5 + k), k4[0], 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 5; k++) begin
        int  g;
        logic t;
        k4 = IW'(k);
        g  = blk * 5 + k;
        t  = (g == 2 || g == 5 || g == 8) ? ~k4[0] : k4[0];
        step(1'b0, 4'd0, 1'b0, 1'b1, t, 1'b0);
      end
    end
`ifdef BP_FE_BP_UPDATE_STATS_EN
    check("stat_res_10", stat_resolved_o, 32'd10);
    check("stat_mis_3", stat_mispred_o, 32'd3);
`else
    check("stat_res_off", stat_resolved_o, 32'd0);
    check("stat_mis_off", stat_mispred_o, 32'd0);
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), IW'($urandom), 1'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
